// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- 32-bit integer ALU with a registered 64-bit HI:LO result.
//
// Feeds the Z register pair (ZHI/ZLO) of the bus-based CPU. Every op is
// evaluated combinationally. The result is captured on the rising clk edge,
// which gives a latency of one cycle. There is no handshake and no enable.
//
// Ports
//   clk     in   1   system clock, rising edge
//   clr     in   1   asynchronous active-high clear; result = 0 while high
//   a       in   32  operand A
//   b       in   32  operand B; b[4:0] is the shift/rotate amount
//   op      in   4   operation select (see OP_* below)
//   result  out  64  registered result, [63:32] = HI, [31:0] = LO
//
// Optional build macro ALU_FLAGS_EN adds three registered flag outputs:
//   zero    out  1   result == 0
//   neg     out  1   result[63] for MUL, result[31] for all other ops
//   ovf     out  1   signed overflow on ADD/SUB/NEG, or the DIV overflow case
//
// Sub-modules in this file:
//   alu_rot_stage  one fixed-distance stage of the right rotator
//   alu_rotr       5-stage logarithmic right rotator
//   alu_div_row    one row of a restoring divider
//   alu_divu       32-row combinational unsigned divider
// ----------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
`ifdef ALU_FLAGS_EN
    output logic        zero,
    output logic        neg,
    output logic        ovf,
`endif
    output logic [63:0] result
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // ------------------------------------------------------------------
    // Add / subtract / negate (32-bit, wrap, no carry into HI)
    // ------------------------------------------------------------------
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] neg_res;

    assign add_res = a + b;
    assign sub_res = a - b;
    assign neg_res = 32'd0 - a;

    // ------------------------------------------------------------------
    // Shifts and rotates share one right rotator.
    // A left rotate by s is the same as a right rotate by (32 - s) mod 32.
    // The logical shifts are rotates with the wrapped-around bits masked off.
    // SHRA then refills the masked bits with the sign of a.
    // ------------------------------------------------------------------
    logic [4:0]  shamt;
    logic        rot_left;
    logic [4:0]  rot_amt;
    logic [31:0] rot_out;
    logic [31:0] rmask;
    logic [31:0] lmask;
    logic [31:0] shr_res;
    logic [31:0] shra_res;
    logic [31:0] shl_res;

    assign shamt    = b[4:0];
    assign rot_left = (op == OP_SHL) || (op == OP_ROL);
    assign rot_amt  = rot_left ? (5'd0 - shamt) : shamt;

    alu_rotr u_rotr (
        .din  (a),
        .amt  (rot_amt),
        .dout (rot_out)
    );

    assign rmask    = 32'hFFFF_FFFF >> shamt;
    assign lmask    = 32'hFFFF_FFFF << shamt;
    assign shr_res  = rot_out & rmask;
    assign shra_res = shr_res | ({32{a[31]}} & ~rmask);
    assign shl_res  = rot_out & lmask;

    // ------------------------------------------------------------------
    // Signed multiply, full 64-bit product
    // ------------------------------------------------------------------
    logic signed [63:0] mul_res;

    assign mul_res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // ------------------------------------------------------------------
    // Signed divide done as an unsigned divide on the magnitudes.
    // The quotient is negated when the operand signs differ.
    // The remainder takes the sign of a, so it truncates toward zero.
    // Divide-by-zero and INT_MIN / -1 are overridden explicitly.
    // ------------------------------------------------------------------
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic        div_ovf;
    logic [63:0] div_res;

    assign abs_a   = a[31] ? (32'd0 - a) : a;
    assign abs_b   = b[31] ? (32'd0 - b) : b;
    assign div_ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);

    alu_divu u_divu (
        .num (abs_a),
        .den (abs_b),
        .quo (uquo),
        .rem (urem)
    );

    always_comb begin
        div_res = '0;
        if (b == 32'd0) begin
            div_res = {a, 32'hFFFF_FFFF};
        end else if (div_ovf) begin
            div_res = {32'd0, INT_MIN};
        end else begin
            div_res[63:32] = a[31] ? (32'd0 - urem) : urem;
            div_res[31:0]  = (a[31] ^ b[31]) ? (32'd0 - uquo) : uquo;
        end
    end

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [63:0] res_nxt;

    always_comb begin
        res_nxt = '0;
        case (op)
            OP_AND:  res_nxt = {32'd0, a & b};
            OP_OR:   res_nxt = {32'd0, a | b};
            OP_ADD:  res_nxt = {32'd0, add_res};
            OP_SUB:  res_nxt = {32'd0, sub_res};
            OP_MUL:  res_nxt = mul_res;
            OP_DIV:  res_nxt = div_res;
            OP_SHR:  res_nxt = {32'd0, shr_res};
            OP_SHRA: res_nxt = {32'd0, shra_res};
            OP_SHL:  res_nxt = {32'd0, shl_res};
            OP_ROR:  res_nxt = {32'd0, rot_out};
            OP_ROL:  res_nxt = {32'd0, rot_out};
            OP_NEG:  res_nxt = {32'd0, neg_res};
            OP_NOT:  res_nxt = {32'd0, ~a};
            default: res_nxt = '0;  // 13-15 reserved
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            result <= '0;
        end else begin
            result <= res_nxt;
        end
    end

`ifdef ALU_FLAGS_EN
    // ------------------------------------------------------------------
    // Status flags, registered alongside result
    // ------------------------------------------------------------------
    logic zero_nxt;
    logic neg_nxt;
    logic ovf_nxt;

    assign zero_nxt = (res_nxt == 64'd0);
    assign neg_nxt  = (op == OP_MUL) ? res_nxt[63] : res_nxt[31];

    always_comb begin
        ovf_nxt = 1'b0;
        case (op)
            // same-sign operands producing an opposite-sign sum
            OP_ADD:  ovf_nxt = (a[31] == b[31]) && (add_res[31] != a[31]);
            // opposite-sign operands where the difference flips away from a
            OP_SUB:  ovf_nxt = (a[31] != b[31]) && (sub_res[31] != a[31]);
            OP_NEG:  ovf_nxt = (a == INT_MIN);
            OP_DIV:  ovf_nxt = div_ovf;
            default: ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            zero <= zero_nxt;
            neg  <= neg_nxt;
            ovf  <= ovf_nxt;
        end
    end
`endif

endmodule

// ----------------------------------------------------------------------------
// alu_rot_stage -- conditional right rotate by the fixed distance SH.
//   en    in   1   apply the rotate
//   din   in   32  input word
//   dout  out  32  rotated (or passed-through) word
// ----------------------------------------------------------------------------
module alu_rot_stage #(
    parameter int SH = 1
) (
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = en ? {din[SH-1:0], din[31:SH]} : din;

endmodule

// ----------------------------------------------------------------------------
// alu_rotr -- logarithmic right rotator. Stage g rotates by 2**g when amt[g]
// is set.
//   din   in   32  word to rotate
//   amt   in   5   rotate distance
//   dout  out  32  rotated word
// ----------------------------------------------------------------------------
module alu_rotr (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    logic [5:0][31:0] rot_chain;

    assign rot_chain[0] = din;

    for (genvar g = 0; g < 5; g++) begin : g_stage
        alu_rot_stage #(.SH(1 << g)) u_stage (
            .en   (amt[g]),
            .din  (rot_chain[g]),
            .dout (rot_chain[g+1])
        );
    end

    assign dout = rot_chain[5];

endmodule

// ----------------------------------------------------------------------------
// alu_div_row -- one restoring-division step.
// It shifts the next dividend bit into the partial remainder and subtracts
// the divisor when it fits. Because rem_in < den, the trial value is below
// 2*den. The subtraction result is therefore always below den, so it fits in
// 32 bits and a 32-bit subtract is exact.
//   rem_in   in   32  partial remainder from the previous row
//   nbit     in   1   next dividend bit (MSB first)
//   den      in   32  divisor
//   rem_out  out  32  updated partial remainder
//   qbit     out  1   quotient bit for this row
// ----------------------------------------------------------------------------
module alu_div_row (
    input  logic [31:0] rem_in,
    input  logic        nbit,
    input  logic [31:0] den,
    output logic [31:0] rem_out,
    output logic        qbit
);

    logic [32:0] trial;
    logic [31:0] diff;

    assign trial   = {rem_in, nbit};
    assign diff    = trial[31:0] - den;
    assign qbit    = (trial >= {1'b0, den});
    assign rem_out = qbit ? diff : trial[31:0];

endmodule

// ----------------------------------------------------------------------------
// alu_divu -- single-cycle 32/32 unsigned divider, 32 rows of alu_div_row.
// A zero divisor yields an all-ones quotient. The caller overrides that case.
//   num  in   32  dividend
//   den  in   32  divisor
//   quo  out  32  quotient
//   rem  out  32  remainder
// ----------------------------------------------------------------------------
module alu_divu (
    input  logic [31:0] num,
    input  logic [31:0] den,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [32:0][31:0] rem_chain;

    assign rem_chain[0] = '0;

    for (genvar i = 0; i < 32; i++) begin : g_row
        alu_div_row u_row (
            .rem_in  (rem_chain[i]),
            .nbit    (num[31-i]),
            .den     (den),
            .rem_out (rem_chain[i+1]),
            .qbit    (quo[31-i])
        );
    end

    assign rem = rem_chain[32];

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// A behavioural model predicts the registered result every cycle, and a
// negedge monitor compares the DUT against it. Directed vectors carry
// hand-computed expectations that pin both the DUT and the model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic [3:0]  op  = '0;
    logic [63:0] result;
`ifdef ALU_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk    (clk),
        .clr    (clr),
        .a      (a),
        .b      (b),
        .op     (op),
`ifdef ALU_FLAGS_EN
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf),
`endif
        .result (result)
    );

    // ------------------------------------------------------------------
    // Reference model, written straight from the op definitions
    // ------------------------------------------------------------------
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] o);
        longint             sx;
        longint             sy;
        longint             q;
        longint             r;
        int                 sh;
        logic signed [31:0] xs;
        logic [31:0]        t;
        logic [63:0]        xx;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        xs = x;
        xx = {x, x};
        model = '0;
        case (o)
            4'd0:  model = {32'd0, x & y};
            4'd1:  model = {32'd0, x | y};
            4'd2:  model = {32'd0, x + y};
            4'd3:  model = {32'd0, x - y};
            4'd4:  model = sx * sy;
            4'd5: begin
                if (y == 32'd0) begin
                    model = {x, 32'hFFFF_FFFF};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    model = {32'd0, 32'h8000_0000};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    model = {r[31:0], q[31:0]};
                end
            end
            4'd6:  model = {32'd0, x >> sh};
            4'd7: begin
                t = xs >>> sh;
                model = {32'd0, t};
            end
            4'd8:  model = {32'd0, x << sh};
            4'd9: begin
                xx = xx >> sh;
                model = {32'd0, xx[31:0]};
            end
            4'd10: begin
                xx = xx << sh;
                model = {32'd0, xx[63:32]};
            end
            4'd11: model = {32'd0, 32'd0 - x};
            4'd12: model = {32'd0, ~x};
            default: model = '0;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    // {zero, neg, ovf}; overflow is judged on the exact integer result
    function automatic logic [2:0] model_flags(input logic [31:0] x, input logic [31:0] y,
                                               input logic [3:0] o);
        logic [63:0] r;
        longint      v;
        logic        f_ovf;
        r = model(x, y, o);
        f_ovf = 1'b0;
        v = 0;
        if (o == 4'd2) v = longint'($signed(x)) + longint'($signed(y));
        if (o == 4'd3) v = longint'($signed(x)) - longint'($signed(y));
        if (o == 4'd11) v = -longint'($signed(x));
        if (o == 4'd2 || o == 4'd3 || o == 4'd11)
            f_ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        if (o == 4'd5) f_ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        model_flags = {r == 64'd0, (o == 4'd4) ? r[63] : r[31], f_ovf};
    endfunction
`endif

    // ------------------------------------------------------------------
    // Prediction and per-cycle compare
    // ------------------------------------------------------------------
    logic [63:0] exp_res = '0;
    logic [2:0]  exp_flg = '0;
    bit          mon_en  = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            exp_res <= '0;
            exp_flg <= '0;
        end else begin
            exp_res <= model(a, b, op);
`ifdef ALU_FLAGS_EN
            exp_flg <= model_flags(a, b, op);
`endif
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (result !== exp_res) begin
                errors++;
                $display("FAIL model-cmp t=%0t op=%0d a=%h b=%h: got %h expected %h",
                         $time, op, a, b, result, exp_res);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero, neg, ovf} !== exp_flg) begin
                errors++;
                $display("FAIL flag-cmp t=%0t: got %b expected %b", $time,
                         {zero, neg, ovf}, exp_flg);
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Directed checks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Called at posedge+1: drive, let one edge capture, check the result
    // against the literal, and cross-check the model against it too.
    task automatic vec(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop,
                       input logic [63:0] want, input string name);
        a  = va;
        b  = vb;
        op = vop;
        @(posedge clk);
        #1;
        chk(name, result, want);
        chk({name, "-model"}, model(va, vb, vop), want);
    endtask

    logic [31:0] pats [0:6];

    initial begin
        pats[0] = 32'h0000_0000;
        pats[1] = 32'h0000_0001;
        pats[2] = 32'hFFFF_FFFF;
        pats[3] = 32'h8000_0000;
        pats[4] = 32'h7FFF_FFFF;
        pats[5] = 32'h1234_5678;
        pats[6] = 32'hFFFF_FF85;

        // Reset held with changing inputs
        clr = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset", result, 64'd0);

        // First capture after clr falls
        clr = 1'b0;
        vec(32'd1, 32'd0, 4'd0, 64'd0, "and-after-reset");
        vec(32'd1, 32'd0, 4'd1, 64'd1, "or");
        vec(32'h0000_F0F0, 32'h0000_FF00, 4'd0, 64'h0000_F000, "and");

        vec(32'd12, 32'd28, 4'd2, 64'd40, "add");
        vec(32'd32, 32'd20, 4'd3, 64'd12, "sub");
        vec(32'd0, 32'd1, 4'd3, 64'h0000_0000_FFFF_FFFF, "sub-wrap");
        vec(32'd8, 32'd0, 4'd11, 64'h0000_0000_FFFF_FFF8, "neg");

        vec(32'd3, 32'd4, 4'd4, 64'd12, "mul");
        vec(32'hFFFF_FFFD, 32'd4, 4'd4, 64'hFFFF_FFFF_FFFF_FFF4, "mul-neg");
        vec(32'h8000_0000, 32'h8000_0000, 4'd4, 64'h4000_0000_0000_0000, "mul-min");

        vec(32'd24, 32'd12, 4'd5, 64'h0000_0000_0000_0002, "div");
        vec(32'd25, 32'd7, 4'd5, 64'h0000_0004_0000_0003, "div-rem");
        vec(32'hFFFF_FFE7, 32'd7, 4'd5, 64'hFFFF_FFFC_FFFF_FFFD, "div-neg");
        vec(32'd100, 32'd0, 4'd5, 64'h0000_0064_FFFF_FFFF, "div-zero");
        vec(32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 64'h0000_0000_8000_0000, "div-ovf");

        vec(32'd4, 32'd2, 4'd6, 64'd1, "shr");
        vec(32'd8, 32'd2, 4'd7, 64'd2, "shra");
        vec(32'h8000_0000, 32'd4, 4'd7, 64'h0000_0000_F800_0000, "shra-sign");
        vec(32'd4, 32'd1, 4'd8, 64'd8, "shl");
        vec(32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'd8, 64'h0000_0000_DEAD_BEEF, "shl-zero-amt");

        vec(32'd4, 32'd1, 4'd9, 64'd2, "ror");
        vec(32'd1, 32'd1, 4'd9, 64'h0000_0000_8000_0000, "ror-wrap");
        vec(32'h1234_5678, 32'h0000_0024, 4'd9, 64'h0000_0000_8123_4567, "ror-hi-bits");
        vec(32'hFFFF_FFFC, 32'd1, 4'd10, 64'h0000_0000_FFFF_FFF9, "rol");

        vec(32'd4, 32'd0, 4'd12, 64'h0000_0000_FFFF_FFFB, "not");
        vec(32'd5, 32'd5, 4'd13, 64'd0, "reserved13");
        vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 64'd0, "reserved15");

`ifdef ALU_FLAGS_EN
        vec(32'h7FFF_FFFF, 32'd1, 4'd2, 64'h0000_0000_8000_0000, "add-ovf");
        chk("add-ovf-flags", {61'd0, zero, neg, ovf}, 64'd3);
`endif

        // Asynchronous clear between edges while result is nonzero
        vec(32'd4, 32'd0, 4'd12, 64'h0000_0000_FFFF_FFFB, "not-before-clr");
        #3;
        clr = 1'b1;
        #1;
        chk("async-clr", result, 64'd0);
        @(posedge clk);
        #1;
        chk("clr-held", result, 64'd0);
        clr = 1'b0;
        vec(32'd5, 32'd6, 4'd2, 64'd11, "add-after-clr");

        // Operand sweep over every op; the monitor checks each cycle
        for (int o = 0; o < 16; o++) begin
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < 7; j++) begin
                    a  = pats[i];
                    b  = pats[j];
                    op = 4'(o);
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int s = 0; s < 32; s++) begin
            a  = 32'hA5C3_0F81;
            b  = 32'(s);
            op = 4'(6 + (s % 5));
            @(posedge clk);
            #1;
        end

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
